// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, decode stall/redirect controls and the IF/ID register.
// The master modport belongs to fetch_unit, the slave modport to whatever sits around it.
interface fetch_unit_if #(
    parameter int unsigned WORD = 32
);
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instruction;
    logic            stall;
    logic            redirect;
    logic [WORD-1:0] redirect_pc;
    logic [WORD-1:0] id_instr;
    logic [WORD-1:0] id_pc;
    logic [WORD-1:0] id_npc;
    logic            id_valid;

    modport master (
        output pc,
        input  instruction,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output id_instr,
        output id_pc,
        output id_npc,
        output id_valid
    );

    modport slave (
        input  pc,
        output instruction,
        output stall,
        output redirect,
        output redirect_pc,
        input  id_instr,
        input  id_pc,
        input  id_npc,
        input  id_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC owner, IF/ID register, one-entry stall hold buffer, redirect squash.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter int unsigned     WORD     = 32,
    parameter logic [WORD-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    fetch_unit_if.master       bus
);

    localparam logic [WORD-1:0] STEP = WORD'(PC_STEP);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e          state_q;
    logic [WORD-1:0] pc_q;
    logic [WORD-1:0] inflight_pc_q;
    logic [WORD-1:0] hold_instr_q;
    logic [WORD-1:0] hold_pc_q;
    logic [WORD-1:0] id_instr_q;
    logic [WORD-1:0] id_pc_q;
    logic [WORD-1:0] id_npc_q;
    logic            id_valid_q;

    logic [WORD-1:0] pc_inc_s;
    logic [WORD-1:0] inflight_inc_s;
    logic [WORD-1:0] hold_inc_s;

    assign pc_inc_s       = pc_q + STEP;
    assign inflight_inc_s = inflight_pc_q + STEP;
    assign hold_inc_s     = hold_pc_q + STEP;

    assign bus.pc       = pc_q;
    assign bus.id_instr = id_instr_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_npc   = id_npc_q;
    assign bus.id_valid = id_valid_q;

    // Fetch FSM with PC, in-flight tag, hold buffer and IF/ID register; redirect beats stall beats advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_npc_q      <= '0;
            id_valid_q    <= 1'b0;
        end else if (bus.redirect) begin
            // Data for the old pc_q arrives next cycle while in FILL, where it is never captured.
            pc_q         <= bus.redirect_pc;
            id_valid_q   <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            state_q      <= ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (!bus.stall) begin
                        id_valid_q    <= 1'b0;
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_inc_s;
                        state_q       <= ST_RUN;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        id_instr_q    <= bus.instruction;
                        id_pc_q       <= inflight_pc_q;
                        id_npc_q      <= inflight_inc_s;
                        id_valid_q    <= 1'b1;
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_inc_s;
                    end else begin
                        hold_instr_q <= bus.instruction;
                        hold_pc_q    <= inflight_pc_q;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall) begin
                        id_instr_q    <= hold_instr_q;
                        id_pc_q       <= hold_pc_q;
                        id_npc_q      <= hold_inc_s;
                        id_valid_q    <= 1'b1;
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_inc_s;
                        state_q       <= ST_RUN;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    id_valid_q <= 1'b0;
                    state_q    <= ST_FILL;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;
    logic        load_s;
    logic        stall_cyc_s;

    assign load_s      = !bus.redirect && !bus.stall && ((state_q == ST_RUN) || (state_q == ST_HOLD));
    assign stall_cyc_s = bus.stall && !bus.redirect;

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;

    // Saturating counters of valid IF/ID loads and non-redirect stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            if (load_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_fetched_q <= perf_fetched_q;
            end
            if (stall_cyc_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, stall hold, redirects, PC wrap, async reset, optional perf counters.
// Two instances: default RESET_PC, and RESET_PC = 32'hFFFF_FFFF for the wrap case.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int   errors;
    int   checks;

    fetch_unit_if #(.WORD(32)) fif ();
    fetch_unit_if #(.WORD(32)) fif2 ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_fetched2;
    logic [31:0] perf_stall2;
`endif

    fetch_unit #(.WORD(32), .RESET_PC(32'h0000_0000), .PC_STEP(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef FETCH_PERF_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
`endif
        .bus          (fif.master)
    );

    fetch_unit #(.WORD(32), .RESET_PC(32'hFFFF_FFFF), .PC_STEP(1)) dut2 (
        .clk          (clk),
        .rst_n        (rst2_n),
`ifdef FETCH_PERF_EN
        .perf_fetched (perf_fetched2),
        .perf_stall   (perf_stall2),
`endif
        .bus          (fif2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction memories: data = C0DE_0000 | addr[15:0].
    always @(posedge clk) begin
        fif.instruction  <= 32'hC0DE_0000 | {16'h0000, fif.pc[15:0]};
        fif2.instruction <= 32'hC0DE_0000 | {16'h0000, fif2.pc[15:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] ipc);
        check({tag, "_valid"}, {31'd0, fif.id_valid}, {31'd0, v});
        if (v) begin
            check({tag, "_pc"}, fif.id_pc, ipc);
            check({tag, "_instr"}, fif.id_instr, 32'hC0DE_0000 | (ipc & 32'h0000_FFFF));
            check({tag, "_npc"}, fif.id_npc, ipc + 32'd1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        fif.stall        = 1'b0;
        fif.redirect     = 1'b0;
        fif.redirect_pc  = 32'd0;
        fif2.stall       = 1'b0;
        fif2.redirect    = 1'b0;
        fif2.redirect_pc = 32'd0;

        // 1: reset values, then pipeline fill
        tick();
        tick();
        check("rst_pc", fif.pc, 32'd0);
        check("rst_valid", {31'd0, fif.id_valid}, 32'd0);
        check("rst_id_pc", fif.id_pc, 32'd0);
        check("rst_id_instr", fif.id_instr, 32'd0);
        check("rst_id_npc", fif.id_npc, 32'd0);
        rst_n = 1'b1;
        tick();
        check("e1_pc", fif.pc, 32'd1);
        check_id("e1", 1'b0, 32'd0);
        tick();
        check("e2_pc", fif.pc, 32'd2);
        check_id("e2", 1'b1, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_id("run", 1'b1, i);
        end
        check("e6_pc", fif.pc, 32'd6);

        // 2: three stall cycles with id_pc=4
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_id("stall", 1'b1, 32'd4);
            check("stall_pc", fif.pc, 32'd6);
        end
        fif.stall = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            tick();
            check_id("unstall", 1'b1, i);
        end

        // 3: redirect to 25 with id_pc=8
        fif.redirect    = 1'b1;
        fif.redirect_pc = 32'd25;
        tick();
        fif.redirect = 1'b0;
        check("redir_pc", fif.pc, 32'd25);
        check_id("redir_b1", 1'b0, 32'd0);
        tick();
        check_id("redir_b2", 1'b0, 32'd0);
        tick();
        check_id("redir_tgt", 1'b1, 32'd25);

        // 4: redirect while in HOLD
        fif.stall = 1'b1;
        tick();
        check_id("hold", 1'b1, 32'd25);
        fif.redirect    = 1'b1;
        fif.redirect_pc = 32'd13;
        tick();
        fif.redirect = 1'b0;
        fif.stall    = 1'b0;
        check("hredir_pc", fif.pc, 32'd13);
        check_id("hredir_b1", 1'b0, 32'd0);
        tick();
        check_id("hredir_b2", 1'b0, 32'd0);
        tick();
        check_id("hredir_tgt", 1'b1, 32'd13);
        tick();
        check_id("hredir_next", 1'b1, 32'd14);

        // stall during FILL keeps the bubble and holds the PC
        fif.redirect    = 1'b1;
        fif.redirect_pc = 32'd40;
        tick();
        fif.redirect = 1'b0;
        fif.stall    = 1'b1;
        tick();
        check("fill_stall_pc", fif.pc, 32'd40);
        check_id("fill_stall", 1'b0, 32'd0);
        fif.stall = 1'b0;
        tick();
        check("fill_go_pc", fif.pc, 32'd41);
        check_id("fill_go", 1'b0, 32'd0);
        tick();
        check_id("fill_tgt", 1'b1, 32'd40);

        // 5: RESET_PC = FFFF_FFFF wraps to 0; async reset clears id_valid
        check("w_rst_pc", fif2.pc, 32'hFFFF_FFFF);
        check("w_rst_valid", {31'd0, fif2.id_valid}, 32'd0);
        rst2_n = 1'b1;
        tick();
        check("w_e1_pc", fif2.pc, 32'd0);
        tick();
        check("w_id_pc0", fif2.id_pc, 32'hFFFF_FFFF);
        check("w_id_instr0", fif2.id_instr, 32'hC0DE_FFFF);
        check("w_id_npc0", fif2.id_npc, 32'd0);
        check("w_valid0", {31'd0, fif2.id_valid}, 32'd1);
        tick();
        check("w_id_pc1", fif2.id_pc, 32'd0);
        tick();
        check("w_id_pc2", fif2.id_pc, 32'd1);
        #2;
        rst2_n = 1'b0;
        #1;
        check("w_async_valid", {31'd0, fif2.id_valid}, 32'd0);
        check("w_async_pc", fif2.pc, 32'hFFFF_FFFF);

`ifdef FETCH_PERF_EN
        // 6: 10 fetches then 3 stall cycles from a fresh reset
        rst_n = 1'b0;
        #1;
        check("perf_rst_f", perf_fetched, 32'd0);
        check("perf_rst_s", perf_stall, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
        end
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        fif.stall = 1'b0;
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_stall", perf_stall, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
